// File: rtl/tcni_recv_dma.sv
// Receive-side DMA sequencer: writes incoming NoC packets (header + payload) into a CPU-armed buffer.
// Optional trailer checksum verification is compiled in with TCNI_RECV_CHECKSUM_EN.
module tcni_recv_dma #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MAX_LEN = 64
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic [ADDR_W-1:0] cfg_base_in,
  input  logic              cfg_start_in,
  output logic              busy_out,
  output logic              done_out,
  input  logic              done_ack_in,
  output logic              err_out,
  output logic [15:0]       len_out,
  input  logic [DATA_W-1:0] flit_data_in,
  input  logic              flit_valid_in,
  output logic              flit_ready_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [3:0]        mem_wb_out,
  input  logic              mem_stall_in
);

  localparam logic [15:0]       MAX_L      = 16'(MAX_LEN);
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

`ifdef TCNI_RECV_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_RECV, S_DROP, S_DONE, S_CHECK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_RECV, S_DROP, S_DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, wptr_q, wr_addr;
  logic [15:0]       len_q, count_q;
  logic              accept, wr_en, last_flit, write_pending, held, start_ok, complete;
`ifdef TCNI_RECV_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q;
  logic              chk_err_q;
`endif

  assign accept        = flit_valid_in && flit_ready_out;
  assign last_flit     = (count_q == len_q - 16'd1);
  assign write_pending = (mem_wb_out != 4'b0000);
  assign held          = write_pending && mem_stall_in;
  assign start_ok      = (state_q == S_IDLE) && cfg_start_in && !done_out;
  assign complete      = (state_q == S_DONE) && (!write_pending || !mem_stall_in);
  assign busy_out      = (state_q != S_IDLE);

  always_comb begin
    state_d        = state_q;
    flit_ready_out = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = wptr_q;
    unique case (state_q)
      S_IDLE: if (start_ok) state_d = S_ARMED;
      S_ARMED: begin
        flit_ready_out = !mem_stall_in;
        if (accept) begin
          wr_en   = 1'b1;
          wr_addr = base_q;
          if (flit_data_in[15:0] == 16'd0)      state_d = S_DONE;
          else if (flit_data_in[15:0] > MAX_L)  state_d = S_DROP;
          else                                  state_d = S_RECV;
        end
      end
      S_RECV: begin
        flit_ready_out = !mem_stall_in && !held;
        if (accept) begin
          wr_en = 1'b1;
`ifdef TCNI_RECV_CHECKSUM_EN
          if (last_flit) state_d = S_CHECK;
`else
          if (last_flit) state_d = S_DONE;
`endif
        end
      end
      S_DROP: begin
        flit_ready_out = 1'b1;
        if (accept && last_flit) state_d = S_IDLE;
      end
`ifdef TCNI_RECV_CHECKSUM_EN
      S_CHECK: begin
        flit_ready_out = 1'b1;
        if (accept) state_d = S_DONE;
      end
`endif
      S_DONE: if (complete) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      wptr_q       <= '0;
      len_q        <= '0;
      count_q      <= '0;
      done_out     <= 1'b0;
      err_out      <= 1'b0;
      len_out      <= '0;
      mem_addr_out <= '0;
      mem_data_out <= '0;
      mem_wb_out   <= '0;
`ifdef TCNI_RECV_CHECKSUM_EN
      acc_q        <= '0;
      chk_err_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        base_q  <= cfg_base_in;
        err_out <= 1'b0;
      end
      // A new write can only be accepted while the port is not stalled, so it never clobbers a held one.
      if (wr_en) begin
        mem_addr_out <= wr_addr;
        mem_data_out <= flit_data_in;
        mem_wb_out   <= '1;
      end else if (!mem_stall_in) begin
        mem_wb_out   <= '0;
      end
      if (accept) begin
        unique case (state_q)
          S_ARMED: begin
            len_q   <= flit_data_in[15:0];
            count_q <= '0;
            wptr_q  <= base_q + WORD_BYTES;
`ifdef TCNI_RECV_CHECKSUM_EN
            acc_q     <= flit_data_in;
            chk_err_q <= 1'b0;
`endif
          end
          S_RECV: begin
            count_q <= count_q + 16'd1;
            wptr_q  <= wptr_q + WORD_BYTES;
`ifdef TCNI_RECV_CHECKSUM_EN
            acc_q   <= acc_q ^ flit_data_in;
`endif
          end
          S_DROP: begin
            count_q <= count_q + 16'd1;
            if (last_flit) err_out <= 1'b1;
          end
`ifdef TCNI_RECV_CHECKSUM_EN
          S_CHECK: chk_err_q <= (flit_data_in != acc_q);
`endif
          default: ;
        endcase
      end
      if (complete) begin
        done_out <= 1'b1;
        len_out  <= len_q;
`ifdef TCNI_RECV_CHECKSUM_EN
        if (chk_err_q) err_out <= 1'b1;
`endif
      end else if (done_ack_in) begin
        done_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tcni_recv_dma.sv
// Self-checking bench for tcni_recv_dma: expected memory writes are queued as flits are driven and
// compared against the writes the monitor observes completing on the memory port.
module tb_tcni_recv_dma;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned ML = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] cfg_base;
  logic          cfg_start, done_ack;
  logic          busy, done, err;
  logic [15:0]   len_out;
  logic [DW-1:0] flit_data;
  logic          flit_valid, flit_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [3:0]    mem_wb;
  logic          mem_stall = 1'b0;

  always #5 clk = ~clk;

  tcni_recv_dma #(.DATA_W(DW), .ADDR_W(AW), .MAX_LEN(ML)) dut (
    .clock_in(clk), .reset_in(rst_n), .cfg_base_in(cfg_base), .cfg_start_in(cfg_start),
    .busy_out(busy), .done_out(done), .done_ack_in(done_ack), .err_out(err), .len_out(len_out),
    .flit_data_in(flit_data), .flit_valid_in(flit_valid), .flit_ready_out(flit_ready),
    .mem_addr_out(mem_addr), .mem_data_out(mem_data), .mem_wb_out(mem_wb), .mem_stall_in(mem_stall)
  );

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t         exp_q[$];
  wr_t         obs_q[$];
  int unsigned obs_cyc[$];
  int          checks = 0;
  int          errors = 0;

  int unsigned cyc = 0;
  int unsigned writes_done = 0;
  int unsigned held_cycles = 0, held_bad = 0, stall_ready = 0, bad_wb = 0;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;
  logic          held_valid = 1'b0;

  int unsigned stall_idx = 32'hFFFF_FFFF, stall_len = 0, stall_seq = 0;
  int unsigned seen_seq = 0, stall_used = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Stall generator: holds the write whose ordinal is stall_idx for stall_len cycles.
  always @(negedge clk) begin
    if (stall_seq != seen_seq) begin
      seen_seq   = stall_seq;
      stall_used = 0;
    end
    if (mem_wb == 4'hF && writes_done == stall_idx && stall_used < stall_len) begin
      mem_stall  = 1'b1;
      stall_used = stall_used + 1;
    end else begin
      mem_stall  = 1'b0;
    end
  end

  // Write monitor: records completed writes and held-write behaviour.
  always @(negedge clk) begin
    #2;
    if (rst_n && mem_wb != 4'h0) begin
      if (mem_wb != 4'hF) bad_wb = bad_wb + 1;
      if (held_valid && (mem_addr != held_addr || mem_data != held_data)) held_bad = held_bad + 1;
      if (mem_stall) begin
        held_cycles = held_cycles + 1;
        if (flit_ready) stall_ready = stall_ready + 1;
        held_addr  = mem_addr;
        held_data  = mem_data;
        held_valid = 1'b1;
      end else begin
        obs_q.push_back('{addr: mem_addr, data: mem_data});
        obs_cyc.push_back(cyc);
        writes_done = writes_done + 1;
        held_valid  = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cfg_base = '0; cfg_start = 1'b0; done_ack = 1'b0;
    flit_data = '0; flit_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic start_rx(input logic [AW-1:0] base);
    @(negedge clk);
    cfg_base = base; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic send_flit(input logic [DW-1:0] d, input logic [AW-1:0] a, input bit wr);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    flit_valid = 1'b1; flit_data = d;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge clk);
      #1 ok = flit_ready;
      @(posedge clk);
      if (ok) break;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL flit_accept_timeout data=%h never accepted, required ready within 100 cycles", d);
    end else if (wr) begin
      exp_q.push_back('{addr: a, data: d});
    end
  endtask

  task automatic flit_idle();
    @(negedge clk);
    flit_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (!busy) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_idle_timeout busy=%b required 0", name, busy); end
  endtask

  // Sends header + L payload flits at base, queueing the writes the buffer should receive.
  task automatic send_packet(input logic [AW-1:0] base, input logic [15:0] l, input logic [DW-1:0] p[]);
    logic [DW-1:0] hdr;
    hdr = {16'h00AB, l};
    send_flit(hdr, base, 1'b1);
    for (int unsigned i = 0; i < l; i++)
      send_flit(p[i], base + AW'(4 * (i + 1)), 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({busy, done, err, len_out, flit_ready, mem_wb, mem_addr, mem_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b done=%b err=%b len=%h rdy=%b wb=%h addr=%h data=%h required all 0",
               busy, done, err, len_out, flit_ready, mem_wb, mem_addr, mem_data);
    end
    flit_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (flit_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b required 0", flit_ready); end
    flit_valid = 1'b0;
  endtask

  task automatic test_basic(input logic [AW-1:0] base, input string name, input bit stall);
    logic [DW-1:0] p[];
    wr_t e, o;
    int unsigned hc0, hb0, sr0;
    p = new[3];
    p[0] = 32'hA; p[1] = 32'hB; p[2] = 32'hC;
    do_reset();
    hc0 = held_cycles; hb0 = held_bad; sr0 = stall_ready;
    if (stall) begin
      stall_idx = writes_done + 1; stall_len = 2; stall_seq++;
    end else begin
      stall_idx = 32'hFFFF_FFFF;
    end
    start_rx(base);
    send_packet(base, 16'd3, p);
    flit_idle();
    wait_idle(name);
    stall_idx = 32'hFFFF_FFFF;
    checks++;
    if (done !== 1'b1 || len_out !== 16'd3 || err !== 1'b0) begin
      errors++; $display("FAIL %s_done done=%b len=%0d err=%b required 1/3/0", name, done, len_out, err);
    end
    checks++;
    if (obs_cyc.size() == 4 && obs_cyc[3] - obs_cyc[0] != (stall ? 5 : 3)) begin
      errors++; $display("FAIL %s_write_spacing got %0d cycles required %0d", name, obs_cyc[3] - obs_cyc[0], stall ? 5 : 3);
    end
    if (stall) begin
      checks++;
      if (held_cycles - hc0 != 2 || held_bad != hb0 || stall_ready != sr0) begin
        errors++;
        $display("FAIL %s_hold held=%0d unstable=%0d ready_in_stall=%0d required 2/0/0",
                 name, held_cycles - hc0, held_bad - hb0, stall_ready - sr0);
      end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s_write missing, required addr=%h data=%h", name, e.addr, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL %s_write got addr=%h data=%h required addr=%h data=%h", name, o.addr, o.data, e.addr, e.data);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL %s_extra_writes got %0d required 0", name, obs_q.size()); end
  endtask

  task automatic test_zero_len();
    logic [DW-1:0] p[];
    wr_t o;
    p = new[0];
    do_reset();
    start_rx(32'h2000);
    send_packet(32'h2000, 16'd0, p);
    flit_idle();
    wait_idle("zero");
    checks++;
    if (done !== 1'b1 || len_out !== 16'd0) begin errors++; $display("FAIL zero_done done=%b len=%0d required 1/0", done, len_out); end
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL zero_write_count got %0d required 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      if (o !== exp_q[0]) begin errors++; $display("FAIL zero_hdr got %h/%h required %h/%h", o.addr, o.data, exp_q[0].addr, exp_q[0].data); end
    end
    start_rx(32'h3000);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_while_done busy=%b required 0", busy); end
    done_ack = 1'b1;
    @(negedge clk);
    done_ack = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_ack done=%b required 0", done); end
  endtask

  task automatic test_drop();
    logic [DW-1:0] hdr;
    int unsigned w0;
    do_reset();
    w0 = writes_done;
    start_rx(32'h4000);
    hdr = {16'h0001, 16'(ML + 1)};
    send_flit(hdr, 32'h4000, 1'b1);
    for (int unsigned i = 0; i < ML + 1; i++) send_flit(DW'(i + 100), '0, 1'b0);
    flit_idle();
    wait_idle("drop");
    checks++;
    if (err !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL drop_flags err=%b done=%b required 1/0", err, done); end
    checks++;
    if (writes_done - w0 != 1 || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL drop_writes got %0d writes required 1 header write at 4000", writes_done - w0);
    end
    start_rx(32'h5000);
    #1;
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL drop_restart err=%b busy=%b required 0/1", err, busy); end
  endtask

  task automatic test_reset_mid();
    int unsigned w0;
    do_reset();
    start_rx(32'h6000);
    send_flit({16'h0002, 16'd5}, 32'h6000, 1'b1);
    send_flit(32'h11, 32'h6004, 1'b1);
    send_flit(32'h22, 32'h6008, 1'b1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, len_out, flit_ready, mem_wb, mem_addr, mem_data} !== '0) begin
      errors++; $display("FAIL midreset_outputs busy=%b wb=%h addr=%h required all 0", busy, mem_wb, mem_addr);
    end
    checks++;
    if (obs_q.size() != 3 || obs_q[2] !== exp_q[2]) begin
      errors++; $display("FAIL midreset_prior_writes got %0d required 3", obs_q.size());
    end
    w0 = writes_done;
    @(negedge clk);
    rst_n = 1'b1;
    flit_data = 32'h33;
    repeat (10) @(negedge clk);
    flit_valid = 1'b0;
    checks++;
    if (writes_done != w0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_no_writes got %0d new writes busy=%b required 0/0", writes_done - w0, busy);
    end
  endtask

`ifdef TCNI_RECV_CHECKSUM_EN
  task automatic test_checksum(input bit good, input string name);
    logic [DW-1:0] hdr, tr;
    do_reset();
    hdr = {16'h00AB, 16'd2};
    tr  = hdr ^ 32'h1234_5678 ^ 32'h0F0F_0F0F;
    if (!good) tr = tr ^ 32'h1;
    start_rx(32'h7000);
    send_flit(hdr, 32'h7000, 1'b1);
    send_flit(32'h1234_5678, 32'h7004, 1'b1);
    send_flit(32'h0F0F_0F0F, 32'h7008, 1'b1);
    send_flit(tr, '0, 1'b0);
    flit_idle();
    wait_idle(name);
    checks++;
    if (done !== 1'b1 || err !== !good || obs_q.size() != 3) begin
      errors++; $display("FAIL %s done=%b err=%b writes=%0d required 1/%b/3", name, done, err, obs_q.size(), !good);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic(32'h0000_1000, "basic", 1'b0);
    test_basic(32'h0000_1000, "stall", 1'b1);
    test_basic(32'hFFFF_FFF8, "wrap", 1'b0);
    test_zero_len();
    test_drop();
    test_reset_mid();
`ifdef TCNI_RECV_CHECKSUM_EN
    test_checksum(1'b0, "chk_bad");
    test_checksum(1'b1, "chk_good");
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout bench did not finish, required completion before 200000");
    $fatal(1);
  end

endmodule

// File: doc/tcni_recv_dma.md
Name: tcni_recv_dma

Overview:
- Receive-side DMA sequencer for the tightly coupled network interface (TCNI) in pkt-sim.
- Takes the flit stream arriving from the NoC router and drives the shared memory write port (data/addr/wb) that the NoC interface exposes.
- Writes each packet into a CPU-configured buffer, then raises a sticky completion flag.
- Packets that exceed the buffer are dropped and flagged as errors.

Parameters:
DATA_W, 32, flit and memory word width (matches memword)
ADDR_W, 32, memory address width
MAX_LEN, 64, largest payload length (in flits) accepted into the buffer

Ports:
clock_in  input  1  system clock, all state on rising edge
reset_in  input  1  reset, asynchronous, active-low
cfg_base_in  input  ADDR_W  buffer base byte address, sampled on accepted start
cfg_start_in  input  1  one-cycle pulse that arms the receiver
busy_out  output  1  high in any state other than IDLE
done_out  output  1  sticky packet-complete flag
done_ack_in  input  1  clears done_out
err_out  output  1  sticky error flag, cleared by the next accepted start
len_out  output  16  payload length of the last completed packet
flit_data_in  input  DATA_W  incoming flit
flit_valid_in  input  1  flit valid
flit_ready_out  output  1  flit accepted when valid && ready
mem_addr_out  output  ADDR_W  memory write address
mem_data_out  output  DATA_W  memory write data
mem_wb_out  output  4  byte write enables: 4'b1111 on write cycles, 4'b0000 otherwise
mem_stall_in  input  1  memory port busy, holds the pending write

Behaviour:
- Reset (reset_in low, asynchronous): state IDLE; all outputs 0; internal counters 0.
  - A reset mid-packet aborts immediately; no further writes are issued.
- Header flit format: bits[15:0] = payload length L (flits); bits[31:16] = source id (ignored).
- States:
  - IDLE:
    - flit_ready_out = 0.
    - cfg_start_in && !done_out → latch base, clear err_out, go to ARMED.
    - cfg_start_in while done_out = 1 is ignored.
  - ARMED:
    - flit_ready_out = !mem_stall_in.
    - Accepted header → write header word to base.
    - L == 0 → DONE.
    - L > MAX_LEN → DROP.
    - Otherwise → RECV with count = 0.
  - RECV:
    - flit_ready_out = !mem_stall_in && !pending_write_held.
    - The i-th accepted payload flit (i from 0) is written to base + 4*(i+1).
    - After flit L-1 is accepted → DONE (or CHECK when the optional feature is enabled).
  - DROP:
    - flit_ready_out = 1; mem_stall_in is ignored.
    - Flits are consumed without writes.
    - After L flits: err_out = 1, → IDLE; done_out is not set.
  - DONE:
    - Waits until the final write has left the port.
    - Then done_out = 1, len_out = L, → IDLE.
- Write timing:
  - Memory outputs are registered. Acceptance in cycle N drives mem_wb_out = 4'b1111 with the corresponding addr/data in cycle N+1, for one cycle.
  - If mem_stall_in is high in that cycle, addr/data/wb hold until the first cycle with mem_stall_in low.
  - The write completes in that cycle.
- Back-to-back flits: one write per cycle when mem_stall_in stays low.
- Address arithmetic: modulo 2^ADDR_W. Wrap is allowed and is not an error.
- Simultaneous done_ack_in and completion in the same cycle: the completion wins, so done_out = 1.
- busy_out and cfg_start_in together: the start is ignored.
- flit_valid_in while in IDLE: the flit is not accepted; ready stays 0 and the flit is held by the upstream.

Optional Feature:
- Macro: TCNI_RECV_CHECKSUM_EN.
- Defined:
  - A trailer flit follows the payload, accepted in state CHECK; it is not written.
  - If the trailer is not equal to the XOR of the header and all payload flits: err_out = 1 and done_out = 1 (the packet is still reported).
- Undefined:
  - No CHECK state; the flit following the payload is treated as the next packet's header only after a new cfg_start_in.

Test Plan:
- Reset, base = 0x1000, start, header L = 3, payloads 0xA, 0xB, 0xC, no stall → writes 0x1000 = hdr, 0x1004 = 0xA, 0x1008 = 0xB, 0x100C = 0xC on consecutive cycles; done_out = 1, len_out = 3.
- Same packet with mem_stall_in high for 2 cycles on the second write → write held for 2 cycles with addr/data stable; flit_ready_out = 0 during the stall; the final memory image is unchanged from the previous case.
- Header L = 0 → single header write, done_out = 1, len_out = 0; done_ack_in clears done_out the next cycle.
- Header L = MAX_LEN+1 → header write only, no payload writes, 65 flits consumed; err_out = 1, done_out = 0; the next start clears err_out.
- Assert reset_in low in the middle of RECV after 2 of 5 flits → outputs 0 immediately; no further writes after release.
- With TCNI_RECV_CHECKSUM_EN, L = 2, bad trailer → done_out = 1, err_out = 1; with correct trailer, err_out = 0.
